// File: rtl/obi_mem_arbiter.sv
// Purpose: N-to-1 OBI arbiter, round-robin grant, in-order response routing via an ID FIFO.
// Latency: grant and response are combinational from mem_gnt_i / mem_rvalid_i (0 added cycles).
// Backpressure: address phase held on the selected master until memory grants; a full ID FIFO blocks mem_req_o.
module obi_mem_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_REQ-1:0]                    req_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         wdata_i,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic                                  mem_we_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_o,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
    input  logic                                  mem_rvalid_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {ARB, HOLD} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   held_id_q;
    logic [ID_W-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic [ID_W-1:0]   arb_sel, cand, sel, head_id;
    logic              arb_found, full, empty, push, pop;

    // Round-robin search starting at rr_ptr_q; first requester found wins.
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!arb_found && req_i[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (count_q == '0);
    assign sel     = (state_q == HOLD) ? held_id_q : arb_sel;
    assign head_id = fifo_q[head_q];

    // Address phase: locked to held_id while waiting for grant; full never bypassed by a same-cycle pop.
    always_comb begin
        if (state_q == HOLD) mem_req_o = req_i[held_id_q] && !full;
        else                 mem_req_o = (|req_i) && !full;
        push = mem_req_o && mem_gnt_i;
        gnt_o = '0;
        if (push) gnt_o[sel] = 1'b1;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        mem_we_o    = 1'b0;
        if (mem_req_o) begin
            mem_addr_o  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            mem_be_o    = be_i[int'(sel)*BE_W +: BE_W];
            mem_we_o    = we_i[sel];
        end
    end

    // Response routing: FIFO head names the master; a response with nothing outstanding is dropped.
    always_comb begin
        pop      = mem_rvalid_i && !empty;
        rvalid_o = '0;
        if (pop) rvalid_o[head_id] = 1'b1;
        rdata_o  = mem_rdata_i;
    end

    // Next-state for round-robin pointer, FIFO pointers, occupancy and sticky error.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        err_d    = err_q || (mem_rvalid_i && empty);
        if (push) begin
            rr_ptr_d = ID_W'((int'(sel) + 1) % NUM_REQ);
            tail_d   = (tail_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + 1'b1;
        end
        if (pop) head_d = (head_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Arbitration FSM plus state registers; a dropped request in HOLD releases the lock without a grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            held_id_q <= '0;
            rr_ptr_q  <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        held_id_q <= arb_sel;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (push || !req_i[held_id_q]) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
            rr_ptr_q <= rr_ptr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // ID storage needs no reset; occupancy decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[tail_q] <= sel;
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NR-1:0]        req_i, gnt_o, we_i, rvalid_o;
    logic [NR*DW/8-1:0]   be_i;
    logic [NR*AW-1:0]     addr_i;
    logic [NR*DW-1:0]     wdata_i;
    logic [DW-1:0]        rdata_o, mem_wdata_o, mem_rdata_i;
    logic                 mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, err_o;
    logic [DW/8-1:0]      mem_be_o;
    logic [AW-1:0]        mem_addr_o;
    logic [$clog2(MO+1)-1:0] outstanding_o;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    logic [1:0]  exp_gnt_q [$];
    logic [33:0] exp_rsp_q [$];
    logic [11:0] pat;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: every grant / response the DUT presents is matched against the queues.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (gnt_o != '0) begin
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt_o), 64'h0);
                else                       chk("gnt_order", 64'(gnt_o), 64'(exp_gnt_q.pop_front()));
            end
            if (rvalid_o != '0) begin
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 64'({rvalid_o, rdata_o}), 64'h0);
                else                       chk("rsp_route_data", 64'({rvalid_o, rdata_o}), 64'(exp_rsp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_ni = 1'b0; req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rdata_i = '0; mem_rvalid_i = 1'b0;
        pat = 12'b1011_0010_1101;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_outstanding", 64'(outstanding_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_mem_req", 64'(mem_req_o), 64'h0);
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'h0);
        adv();
        rst_ni = 1'b1;

        // Single read from master 0, response next cycle.
        addr_i[31:0] = 32'h100; req_i = 2'b01; mem_gnt_i = 1'b1;
        exp_gnt_q.push_back(2'b01);
        @(negedge clk_i);
        chk("t1_addr", 64'(mem_addr_o), 64'h100);
        chk("t1_mem_req", 64'(mem_req_o), 64'h1);
        adv();
        req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        exp_rsp_q.push_back({2'b01, 32'hDEAD_BEEF});
        @(negedge clk_i);
        chk("t1_outstanding", 64'(outstanding_o), 64'h1);
        adv();
        mem_rvalid_i = 1'b0;

        // Both masters requesting; pointer now at 1, so grants go 10,01,10,01 until full.
        addr_i = {32'h300, 32'h200}; req_i = 2'b11; mem_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
            @(negedge clk_i);
            chk("t2_addr", 64'(mem_addr_o), (i % 2 == 0) ? 64'h300 : 64'h200);
            adv();
        end
        @(negedge clk_i);
        chk("t4_full_count", 64'(outstanding_o), 64'h4);
        chk("t4_full_blocks", 64'(mem_req_o), 64'h0);
        adv();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA0;
        exp_rsp_q.push_back({2'b10, 32'hA0});
        @(negedge clk_i);
        chk("t4_no_bypass", 64'(mem_req_o), 64'h0);
        adv();
        mem_rvalid_i = 1'b0;
        exp_gnt_q.push_back(2'b10);
        @(negedge clk_i);
        chk("t4_after_pop_count", 64'(outstanding_o), 64'h3);
        chk("t4_after_pop_req", 64'(mem_req_o), 64'h1);
        adv();
        req_i = '0; mem_gnt_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hB0 + 32'(j);
            exp_rsp_q.push_back({(j % 2 == 0) ? 2'b01 : 2'b10, 32'hB0 + 32'(j)});
            @(negedge clk_i);
            adv();
        end
        mem_rvalid_i = 1'b0;

        // Master 1 locked in address phase for 3 ungranted cycles while master 0 joins.
        we_i = 2'b10; be_i = {4'b0011, 4'b1111}; wdata_i = {32'h1111_2222, 32'h3333_4444};
        req_i = 2'b10; mem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("t3_drained", 64'(outstanding_o), 64'h0);
        chk("t3_hold_addr0", 64'(mem_addr_o), 64'h300);
        chk("t3_we", 64'(mem_we_o), 64'h1);
        chk("t3_be", 64'(mem_be_o), 64'h3);
        chk("t3_wdata", 64'(mem_wdata_o), 64'h1111_2222);
        adv();
        req_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("t3_hold_addr", 64'(mem_addr_o), 64'h300);
            chk("t3_hold_req", 64'(mem_req_o), 64'h1);
            adv();
        end
        mem_gnt_i = 1'b1;
        exp_gnt_q.push_back(2'b10);
        @(negedge clk_i);
        chk("t3_grant_addr", 64'(mem_addr_o), 64'h300);
        adv();
        req_i = 2'b01;
        exp_gnt_q.push_back(2'b01);
        @(negedge clk_i);
        chk("t3_m0_addr", 64'(mem_addr_o), 64'h200);
        chk("t3_m0_be", 64'(mem_be_o), 64'hF);
        adv();
        req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC1;
        exp_rsp_q.push_back({2'b10, 32'hC1});
        adv();
        mem_rdata_i = 32'hC0;
        exp_rsp_q.push_back({2'b01, 32'hC0});
        adv();
        mem_rvalid_i = 1'b0; we_i = '0;

        // Steady push+pop at occupancy 2 over 12 transactions (FIFO pointers wrap 3 times).
        for (int i = 0; i < 14; i++) begin
            req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (i < 12) begin
                req_i = pat[i] ? 2'b10 : 2'b01;
                mem_gnt_i = 1'b1;
                exp_gnt_q.push_back(pat[i] ? 2'b10 : 2'b01);
            end
            if (i >= 2) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hC000_0000 + 32'(i - 2);
                exp_rsp_q.push_back({pat[i-2] ? 2'b10 : 2'b01, 32'hC000_0000 + 32'(i - 2)});
            end
            @(negedge clk_i);
            if (i >= 2 && i <= 12) chk("t5_count_steady", 64'(outstanding_o), 64'h2);
            adv();
        end
        req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("t5_drained", 64'(outstanding_o), 64'h0);
        adv();

        // Response with nothing outstanding: dropped, sticky error.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
        @(negedge clk_i);
        chk("t6_no_route", 64'(rvalid_o), 64'h0);
        chk("t6_err_not_yet", 64'(err_o), 64'h0);
        adv();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("t6_err_set", 64'(err_o), 64'h1);
        repeat (3) adv();
        req_i = 2'b01; mem_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_gnt_q.push_back(2'b01);
            adv();
        end
        req_i = '0; mem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("t6_err_sticky", 64'(err_o), 64'h1);
        chk("t6_three_out", 64'(outstanding_o), 64'h3);
        adv();
        rst_ni = 1'b0;
        adv();
        @(negedge clk_i);
        chk("t6_rst_count", 64'(outstanding_o), 64'h0);
        chk("t6_rst_err", 64'(err_o), 64'h0);
        adv();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1;
        @(negedge clk_i);
        chk("t6_stale_rsp_dropped", 64'(rvalid_o), 64'h0);
        adv();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("t6_stale_rsp_err", 64'(err_o), 64'h1);
        adv();

        chk("sb_gnt_drained", 64'(exp_gnt_q.size()), 64'h0);
        chk("sb_rsp_drained", 64'(exp_rsp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
